// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and widths for the register-file write-port arbiter.
//   REG_ADDR_W / DATA_W : register address and data widths
//   wb_req_t            : one register write {addr, data}
//   arb_state_e         : arbiter FSM states (ARB, FORCE)
//   addrOneHot()        : decodes a register address to a one-hot mask
// ---------------------------------------------------------------------------
package wb_arb_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int DATA_W     = 16;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_req_t;

   typedef enum logic {
      ARB   = 1'b0,
      FORCE = 1'b1
   } arb_state_e;

   function automatic logic [NUM_REGS-1:0] addrOneHot(input logic [REG_ADDR_W-1:0] addr);
      return NUM_REGS'(1) << addr;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
// Bundles the pipeline writeback request, the multi-cycle result handshake
// and the register-file write port seen by wb_port_arbiter.
//   pipe_we/pipe_addr/pipe_data : pipeline WB write request
//   mc_valid/mc_ready           : multi-cycle result handshake
//   mc_addr/mc_data             : multi-cycle result payload
//   stall_pipe                  : pipeline must hold (pipe_we low while set)
//   rf_we/rf_addr/rf_data       : registered register-file write port
//   pend_mask                   : registers targeted by buffered results
//   buf_count                   : result buffer occupancy
// Modports: slave = the arbiter, master = the surrounding core / bench.
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if
   import wb_arb_pkg::*;
#(
   parameter int DEPTH = 4
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  pipe_we;
   logic [REG_ADDR_W-1:0] pipe_addr;
   logic [DATA_W-1:0]     pipe_data;
   logic                  mc_valid;
   logic                  mc_ready;
   logic [REG_ADDR_W-1:0] mc_addr;
   logic [DATA_W-1:0]     mc_data;
   logic                  stall_pipe;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0]     rf_data;
   logic [NUM_REGS-1:0]   pend_mask;
   logic [CNT_W-1:0]      buf_count;

   modport slave (
      input  pipe_we, pipe_addr, pipe_data,
      input  mc_valid, mc_addr, mc_data,
      output mc_ready, stall_pipe,
      output rf_we, rf_addr, rf_data,
      output pend_mask, buf_count
   );

   modport master (
      output pipe_we, pipe_addr, pipe_data,
      output mc_valid, mc_addr, mc_data,
      input  mc_ready, stall_pipe,
      input  rf_we, rf_addr, rf_data,
      input  pend_mask, buf_count
   );

endinterface

// File: rtl/wb_arb_fifo.sv
// ---------------------------------------------------------------------------
// wb_arb_fifo
// DEPTH-entry circular buffer of pending multi-cycle register writes.
//   clk, rst       : clock, asynchronous active-high reset
//   push_i, req_i  : write req_i into the tail (caller guarantees not full)
//   pop_i          : drop the head entry (caller guarantees not empty)
//   head_o         : current head entry
//   empty_o        : no entries buffered
//   count_o        : registered occupancy
//   pend_mask_o    : OR of one-hot destination addresses of valid entries
// ---------------------------------------------------------------------------
module wb_arb_fifo
   import wb_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  wb_req_t                      req_i,
   input  logic                         pop_i,
   output wb_req_t                      head_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH):0]       count_o,
   output logic [NUM_REGS-1:0]          pend_mask_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_req_t            mem_q [DEPTH];
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   // Pointer, occupancy and per-entry valid bookkeeping. DEPTH is a power of
   // two, so the pointers wrap by simple overflow.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      valid_d = valid_q;
      if (pop_i) begin
         rdPtr_d          = rdPtr_q + 1'b1;
         valid_d[rdPtr_q] = 1'b0;
      end
      if (push_i) begin
         wrPtr_d          = wrPtr_q + 1'b1;
         valid_d[wrPtr_q] = 1'b1;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state is reset so a mid-operation reset discards every entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Payload storage needs no reset; stale slots are masked by valid_q.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wrPtr_q] <= req_i;
      end
   end

   // Pending-register mask seen by decode, built only from live entries.
   always_comb begin
      pend_mask_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) begin
            pend_mask_o = pend_mask_o | addrOneHot(mem_q[i].addr);
         end
      end
   end

   assign head_o  = mem_q[rdPtr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback and a buffered multi-cycle unit. The pipeline always wins in the
// normal ARB state; buffered results drain in free slots.
// Optional feature (macro WBARB_STARVE_EN): a starvation counter that moves
// the arbiter to FORCE, stalling the pipeline for one slot so the buffer head
// is written. Without the macro stall_pipe is tied low and the buffer drains
// only when pipe_we is low.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   bus_io : wb_port_arbiter_if.slave (pipeline, multi-cycle and rf ports)
// ---------------------------------------------------------------------------
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   wb_port_arbiter_if.slave        bus_io
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   wb_req_t               mcReq;
   wb_req_t               headReq;
   logic                  fifoEmpty;
   logic                  fifoPush;
   logic [CNT_W-1:0]      fifoCount;
   logic                  grantPipe;
   logic                  grantFifo;
   logic                  stallPipe;

   logic                  rfWe_q, rfWe_d;
   logic [REG_ADDR_W-1:0] rfAddr_q, rfAddr_d;
   logic [DATA_W-1:0]     rfData_q, rfData_d;

   // Acceptance looks only at the registered count, so a full buffer refuses
   // a push even in a cycle where the head is popped.
   assign bus_io.mc_ready = (fifoCount < CNT_W'(DEPTH));
   assign fifoPush        = bus_io.mc_valid && bus_io.mc_ready;
   assign mcReq           = '{addr: bus_io.mc_addr, data: bus_io.mc_data};

   wb_arb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifoPush),
      .req_i       (mcReq),
      .pop_i       (grantFifo),
      .head_o      (headReq),
      .empty_o     (fifoEmpty),
      .count_o     (fifoCount),
      .pend_mask_o (bus_io.pend_mask)
   );

`ifdef WBARB_STARVE_EN
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   arb_state_e           state_q, state_d;
   logic [STARVE_W-1:0]  starve_q, starve_d;

   // State register and starvation counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Next state: count cycles a waiting head is passed over; entering FORCE
   // on the edge the count reaches the limit makes stall_pipe rise there.
   // FORCE leaves only once a cycle without pipe_we lets the head through.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      case (state_q)
         ARB: begin
            if (fifoEmpty || grantFifo) begin
               starve_d = '0;
            end else begin
               starve_d = starve_q + 1'b1;
               if (starve_d == STARVE_W'(STARVE_LIMIT)) begin
                  state_d = FORCE;
               end
            end
         end
         FORCE: begin
            starve_d = '0;
            if (!bus_io.pipe_we) begin
               state_d = ARB;
            end
         end
         default: begin
            state_d  = ARB;
            starve_d = '0;
         end
      endcase
   end

   // Outputs: the grant rule is the same in both states because FORCE only
   // relies on the pipeline honouring stall_pipe; a pipe_we in FORCE still
   // wins and the head simply waits.
   always_comb begin
      grantPipe = bus_io.pipe_we;
      grantFifo = !bus_io.pipe_we && !fifoEmpty;
      stallPipe = (state_q == FORCE);
   end
`else
   // Without the starvation guard the pipeline always has priority.
   always_comb begin
      grantPipe = bus_io.pipe_we;
      grantFifo = !bus_io.pipe_we && !fifoEmpty;
      stallPipe = 1'b0;
   end
`endif

   assign bus_io.stall_pipe = stallPipe;

   // Register-file port next values: address and data hold when idle.
   always_comb begin
      rfWe_d   = grantPipe || grantFifo;
      rfAddr_d = rfAddr_q;
      rfData_d = rfData_q;
      if (grantPipe) begin
         rfAddr_d = bus_io.pipe_addr;
         rfData_d = bus_io.pipe_data;
      end else if (grantFifo) begin
         rfAddr_d = headReq.addr;
         rfData_d = headReq.data;
      end
   end

   // Registered write port: a grant appears one cycle later for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rfWe_q   <= 1'b0;
         rfAddr_q <= '0;
         rfData_q <= '0;
      end else begin
         rfWe_q   <= rfWe_d;
         rfAddr_q <= rfAddr_d;
         rfData_q <= rfData_d;
      end
   end

   assign bus_io.rf_we     = rfWe_q;
   assign bus_io.rf_addr   = rfAddr_q;
   assign bus_io.rf_data   = rfData_q;
   assign bus_io.buf_count = fifoCount;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed bench for wb_port_arbiter. Every write the arbiter should issue is
// queued when its stimulus is applied; a monitor on the falling clock edge
// pops the queue whenever rf_we is high. Status outputs (count, mask, ready,
// stall) are checked directly one time unit after the rising edge.
// The starvation scenario follows WBARB_STARVE_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;
   import wb_arb_pkg::*;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 8;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   wb_req_t expQ [$];

   wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

   wb_port_arbiter #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scoreboard monitor: every observed write must match the next queued one.
   always @(negedge clk) begin
      if (!rst && bus.rf_we) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL rf_write_unexpected: got R%0d=0x%0h, expected no write",
                     bus.rf_addr, bus.rf_data);
         end else begin
            wb_req_t exp;
            exp = expQ.pop_front();
            if (bus.rf_addr !== exp.addr || bus.rf_data !== exp.data) begin
               errors++;
               $display("[TB] FAIL rf_write: got R%0d=0x%0h, expected R%0d=0x%0h",
                        bus.rf_addr, bus.rf_data, exp.addr, exp.data);
            end
         end
      end
   end

   task automatic applyStimulus(input logic pWe, input logic [3:0] pAddr,
                                input logic [15:0] pData, input logic mValid,
                                input logic [3:0] mAddr, input logic [15:0] mData);
      bus.pipe_we   = pWe;
      bus.pipe_addr = pAddr;
      bus.pipe_data = pData;
      bus.mc_valid  = mValid;
      bus.mc_addr   = mAddr;
      bus.mc_data   = mData;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic expectWrite(input logic [3:0] addr, input logic [15:0] data);
      wb_req_t e;
      e.addr = addr;
      e.data = data;
      expQ.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] fillAddr [4];
   logic [3:0] rstAddr  [3];

   initial begin
      fillAddr = '{4'd1, 4'd2, 4'd9, 4'd12};
      rstAddr  = '{4'd4, 4'd6, 4'd10};

      // Reset state
      rst = 1'b1;
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_rf_we", 32'(bus.rf_we), 32'd0);
      checkOutput("reset_rf_addr", 32'(bus.rf_addr), 32'd0);
      checkOutput("reset_rf_data", 32'(bus.rf_data), 32'd0);
      checkOutput("reset_stall", 32'(bus.stall_pipe), 32'd0);
      checkOutput("reset_buf_count", 32'(bus.buf_count), 32'd0);
      checkOutput("reset_pend_mask", 32'(bus.pend_mask), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("ready_after_reset", 32'(bus.mc_ready), 32'd1);

      // Pipeline write R3 = 0x1234, then idle: address/data hold
      applyStimulus(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0);
      expectWrite(4'd3, 16'h1234);
      tick();
      checkOutput("pipe_rf_we", 32'(bus.rf_we), 32'd1);
      checkOutput("pipe_rf_addr", 32'(bus.rf_addr), 32'd3);
      checkOutput("pipe_rf_data", 32'(bus.rf_data), 32'h1234);
      checkOutput("pipe_pend_mask", 32'(bus.pend_mask), 32'd0);
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
      checkOutput("idle_rf_we", 32'(bus.rf_we), 32'd0);
      checkOutput("hold_rf_addr", 32'(bus.rf_addr), 32'd3);
      checkOutput("hold_rf_data", 32'(bus.rf_data), 32'h1234);

      // Single multi-cycle result R5 = 0xBEEF in an idle pipeline
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'hBEEF);
      expectWrite(4'd5, 16'hBEEF);
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      checkOutput("mc_buf_count", 32'(bus.buf_count), 32'd1);
      checkOutput("mc_pend_mask", 32'(bus.pend_mask), 32'h0020);
      checkOutput("mc_no_fallthrough", 32'(bus.rf_we), 32'd0);
      tick();
      checkOutput("mc_rf_we", 32'(bus.rf_we), 32'd1);
      checkOutput("mc_pend_cleared", 32'(bus.pend_mask), 32'd0);
      checkOutput("mc_buf_empty", 32'(bus.buf_count), 32'd0);
      tick();
      checkOutput("mc_single_cycle", 32'(bus.rf_we), 32'd0);

      // Fill the buffer while the pipeline writes R14 every cycle
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 4'hE, 16'(16'hA000 + i), 1'b1, fillAddr[i], 16'(16'hC000 + i));
         expectWrite(4'hE, 16'(16'hA000 + i));
         tick();
      end
      checkOutput("full_buf_count", 32'(bus.buf_count), 32'd4);
      checkOutput("full_ready", 32'(bus.mc_ready), 32'd0);
      checkOutput("full_pend_mask", 32'(bus.pend_mask), 32'h1206);

      // A push offered to a full buffer is refused
      applyStimulus(1'b1, 4'hE, 16'hA004, 1'b1, 4'hF, 16'hDEAD);
      expectWrite(4'hE, 16'hA004);
      tick();
      checkOutput("overflow_buf_count", 32'(bus.buf_count), 32'd4);
      checkOutput("overflow_pend_mask", 32'(bus.pend_mask), 32'h1206);

      // Full buffer: pop in the same cycle as mc_valid does not admit the push
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'hF, 16'hDEAD);
      expectWrite(4'd1, 16'hC000);
      tick();
      checkOutput("pop_full_buf_count", 32'(bus.buf_count), 32'd3);
      checkOutput("pop_full_ready", 32'(bus.mc_ready), 32'd1);
      checkOutput("pop_full_pend_mask", 32'(bus.pend_mask), 32'h1204);

      // The held push is accepted on the next cycle
      applyStimulus(1'b1, 4'hE, 16'hA005, 1'b1, 4'hF, 16'hDEAD);
      expectWrite(4'hE, 16'hA005);
      tick();
      checkOutput("refill_buf_count", 32'(bus.buf_count), 32'd4);
      checkOutput("refill_pend_mask", 32'(bus.pend_mask), 32'h9204);

      // Drain in FIFO order, pointers wrapping
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      expectWrite(4'd2,  16'hC001);
      expectWrite(4'd9,  16'hC002);
      expectWrite(4'd12, 16'hC003);
      expectWrite(4'hF,  16'hDEAD);
      repeat (4) tick();
      checkOutput("drain_buf_count", 32'(bus.buf_count), 32'd0);
      checkOutput("drain_pend_mask", 32'(bus.pend_mask), 32'd0);
      checkOutput("drain_last_addr", 32'(bus.rf_addr), 32'hF);
      tick();
      checkOutput("drain_idle", 32'(bus.rf_we), 32'd0);

      // Starvation: one entry R7 behind a continuously writing pipeline
      applyStimulus(1'b1, 4'hE, 16'hB000, 1'b1, 4'd7, 16'h7777);
      expectWrite(4'hE, 16'hB000);
      tick();
`ifdef WBARB_STARVE_EN
      for (int k = 1; k <= STARVE_LIMIT; k++) begin
         checkOutput("starve_stall_low", 32'(bus.stall_pipe), 32'd0);
         applyStimulus(1'b1, 4'hE, 16'(16'hB000 + k), 1'b0, 4'd0, 16'h0);
         expectWrite(4'hE, 16'(16'hB000 + k));
         tick();
      end
      checkOutput("starve_stall_high", 32'(bus.stall_pipe), 32'd1);
      checkOutput("starve_buf_count", 32'(bus.buf_count), 32'd1);
`else
      for (int k = 1; k <= 10; k++) begin
         checkOutput("nostarve_stall_low", 32'(bus.stall_pipe), 32'd0);
         applyStimulus(1'b1, 4'hE, 16'(16'hB000 + k), 1'b0, 4'd0, 16'h0);
         expectWrite(4'hE, 16'(16'hB000 + k));
         tick();
      end
      checkOutput("nostarve_buf_count", 32'(bus.buf_count), 32'd1);
`endif
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      expectWrite(4'd7, 16'h7777);
      tick();
      checkOutput("starve_rf_we", 32'(bus.rf_we), 32'd1);
      checkOutput("starve_rf_addr", 32'(bus.rf_addr), 32'd7);
      checkOutput("starve_stall_release", 32'(bus.stall_pipe), 32'd0);
      checkOutput("starve_buf_empty", 32'(bus.buf_count), 32'd0);

      // Reset mid-stream with three entries buffered
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'd0, 16'(16'hD000 + i), 1'b1, rstAddr[i], 16'(16'hE000 + i));
         expectWrite(4'd0, 16'(16'hD000 + i));
         tick();
      end
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      checkOutput("prereset_buf_count", 32'(bus.buf_count), 32'd3);
      checkOutput("prereset_pend_mask", 32'(bus.pend_mask), 32'h0450);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midreset_rf_we", 32'(bus.rf_we), 32'd0);
      checkOutput("midreset_buf_count", 32'(bus.buf_count), 32'd0);
      checkOutput("midreset_pend_mask", 32'(bus.pend_mask), 32'd0);
      tick();
      rst = 1'b0;
      repeat (4) tick();
      checkOutput("postreset_rf_we", 32'(bus.rf_we), 32'd0);
      checkOutput("postreset_buf_count", 32'(bus.buf_count), 32'd0);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
